press_classifier: RTL and testbench

PRESS_CLASSIFIER -- requirements
Module: press_classifier

---
 rtl/press_classifier.sv | 158 +++++++++++++++
 tb/tb_press_classifier.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/press_classifier.sv
`default_nettype none
// ============================================================================
// Module   : press_classifier
// Brief    : Classifies a filtered button level into short, long and double
//            press events, and keeps a running event count.
// Revision : 1.0 - initial release
// ============================================================================
module press_classifier #(
    parameter int LONG_CYCLES = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level_in,
    output logic       short_press,
    output logic       long_press,
    output logic       double_press,
    output logic       busy,
    output logic [7:0] event_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESS1    = 3'd1,
        S_GAP       = 3'd2,
        S_PRESS2    = 3'd3,
        S_LONG_HELD = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_LONG    = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] c_GAP     = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic [7:0]       event_count_q, event_count_d;

    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_rise    = level_in & ~level_q;
    assign w_fall    = ~level_in & level_q;
    assign w_cnt_inc = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + c_CNT_ONE;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_rise) begin
                    state_d = S_PRESS1;
                    cnt_d   = c_CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            S_PRESS1: begin
                if (w_fall) begin
                    // The falling sample is already the first low of the gap.
                    if (GAP_CYCLES <= 1) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        short_d = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = c_CNT_ONE;
                    end
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc >= c_LONG) begin
                        state_d = S_LONG_HELD;
                        long_d  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (w_rise) begin
                    state_d = S_PRESS2;
                    cnt_d   = c_CNT_ONE;
                end else if (w_cnt_inc >= c_GAP) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            S_PRESS2: begin
                if (w_fall) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    double_d = 1'b1;
                end else begin
                    cnt_d = w_cnt_inc;
                    // A second click held long reports the first click as short.
                    if (w_cnt_inc >= c_LONG) begin
                        state_d = S_LONG_HELD;
                        short_d = 1'b1;
                        long_d  = 1'b1;
                    end
                end
            end
            S_LONG_HELD: begin
                if (w_fall) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign event_count_d = event_count_q + {7'd0, short_d} + {7'd0, long_d}
                         + {7'd0, double_d};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            level_q       <= 1'b1;
            short_q       <= 1'b0;
            long_q        <= 1'b0;
            double_q      <= 1'b0;
            event_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            level_q       <= level_in;
            short_q       <= short_d;
            long_q        <= long_d;
            double_q      <= double_d;
            event_count_q <= event_count_d;
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;
    assign busy         = (state_q != S_IDLE);
    assign event_count  = event_count_q;

endmodule
`default_nettype wire

// File: tb/tb_press_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_press_classifier
// Brief    : Directed scoreboard bench for press_classifier (LONG=8, GAP=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_press_classifier;

    localparam logic [2:0] c_NONE   = 3'b000;
    localparam logic [2:0] c_SHORT  = 3'b001;
    localparam logic [2:0] c_LONG   = 3'b010;
    localparam logic [2:0] c_DOUBLE = 3'b100;

    logic       clk;
    logic       rst;
    logic       level_in;
    logic       short_press;
    logic       long_press;
    logic       double_press;
    logic       busy;
    logic [7:0] event_count;

    int         n_checks;
    int         n_fails;
    int         exp_ec;
    logic [2:0] sb_q[$];

    press_classifier #(
        .LONG_CYCLES(8),
        .GAP_CYCLES (4),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .level_in    (level_in),
        .short_press (short_press),
        .long_press  (long_press),
        .double_press(double_press),
        .busy        (busy),
        .event_count (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one sample, expecting the given pulse set after the edge.
    task automatic tick(input logic lvl, input logic [2:0] ev);
        logic [2:0] exp_ev;
        level_in = lvl;
        sb_q.push_back(ev);
        @(posedge clk);
        #1;
        exp_ev = sb_q.pop_front();
        if (!rst) exp_ec = (exp_ec + int'(ev[0]) + int'(ev[1]) + int'(ev[2])) % 256;
        check("pulses", {5'd0, double_press, long_press, short_press}, {5'd0, exp_ev});
    endtask

    task automatic run(input logic lvl, input int n);
        for (int i = 0; i < n; i++) tick(lvl, c_NONE);
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_busy"}, {7'd0, busy}, 8'd0);
        check({tag, "_count"}, event_count, 8'(exp_ec));
    endtask

    task automatic do_reset(input logic lvl, input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick(lvl, c_NONE);
            check("reset_count", event_count, 8'd0);
            check("reset_busy", {7'd0, busy}, 8'd0);
        end
        rst = 1'b0;
        exp_ec = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        exp_ec   = 0;
        rst      = 1'b1;
        level_in = 1'b0;
        do_reset(1'b0, 2);
        run(1'b0, 2);
        idle_check("after_reset");

        // Single short press: pulse on the 4th low
        run(1'b1, 1);
        check("press1_busy", {7'd0, busy}, 8'd1);
        run(1'b1, 2);
        run(1'b0, 3);
        tick(1'b0, c_SHORT);
        run(1'b0, 1);
        idle_check("short");

        // Double press
        run(1'b1, 3);
        run(1'b0, 2);
        run(1'b1, 3);
        tick(1'b0, c_DOUBLE);
        run(1'b0, 2);
        idle_check("double");

        // Long hold of 20 cycles, then release with no pulse
        run(1'b1, 7);
        tick(1'b1, c_LONG);
        run(1'b1, 12);
        check("long_busy", {7'd0, busy}, 8'd1);
        run(1'b0, 1);
        idle_check("long");

        // Second press held long: short + long together
        run(1'b1, 2);
        run(1'b0, 1);
        run(1'b1, 7);
        tick(1'b1, c_SHORT | c_LONG);
        run(1'b1, 2);
        run(1'b0, 2);
        idle_check("short_long");

        // 7 highs is not long; 3 lows then rise still makes a double
        run(1'b1, 7);
        run(1'b0, 3);
        run(1'b1, 1);
        tick(1'b0, c_DOUBLE);
        // Immediate rise after a double starts a new press
        run(1'b1, 1);
        check("new_press_busy", {7'd0, busy}, 8'd1);
        run(1'b0, 3);
        tick(1'b0, c_SHORT);
        // Rise right after gap expiry is a fresh press, not a second click
        run(1'b1, 2);
        run(1'b0, 3);
        tick(1'b0, c_SHORT);
        run(1'b0, 1);
        idle_check("boundaries");

        // Level held high through reset is not a press
        do_reset(1'b1, 2);
        run(1'b1, 10);
        idle_check("high_through_reset");
        run(1'b0, 1);
        run(1'b1, 2);
        run(1'b0, 3);
        tick(1'b0, c_SHORT);
        run(1'b0, 1);
        idle_check("after_high_reset");

        // Reset during GAP discards the pending short
        run(1'b1, 2);
        run(1'b0, 2);
        do_reset(1'b0, 1);
        run(1'b0, 6);
        idle_check("reset_gap");

        // Reset during PRESS1 discards the pending press
        run(1'b1, 3);
        do_reset(1'b1, 1);
        run(1'b1, 10);
        run(1'b0, 5);
        idle_check("reset_press1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
